// File: rtl/led_shift_driver.sv
// Serializes a parallel LED snapshot MSB-first onto a 74HC595-style chain, then pulses the latch.
// Frames repeat after REFRESH idle cycles, or sooner on a refresh_now request.
module led_shift_driver #(
  parameter int N_LEDS  = 16,
  parameter int CLK_DIV = 4,
  parameter int REFRESH = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] leds,
  input  logic              refresh_now,
  output logic              led_sclk,
  output logic              led_sdata,
  output logic              led_latch,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(N_LEDS) + 1;
  localparam int WAIT_W = $clog2(REFRESH) + 1;

  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(N_LEDS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(REFRESH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [N_LEDS-1:0]   shreg_q, shreg_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic                sclk_q, sclk_d;
  logic                sdata_q, sdata_d;
  logic                latch_q, latch_d;
  logic                done_q, done_d;
  logic                pending_q, pending_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      div_q     <= '0;
      bitcnt_q  <= '0;
      wcnt_q    <= '0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      div_q     <= div_d;
      bitcnt_q  <= bitcnt_d;
      wcnt_q    <= wcnt_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      latch_q   <= latch_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    div_d     = div_q;
    bitcnt_d  = bitcnt_q;
    wcnt_d    = wcnt_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    latch_d   = latch_q;
    done_d    = 1'b0;
    // Requests made mid-frame are remembered and honoured at the next WAIT.
    pending_d = pending_q | refresh_now;

    case (state_q)
      S_IDLE: begin
        shreg_d  = leds;
        sdata_d  = leds[N_LEDS-1];
        bitcnt_d = BIT_LOAD;
        div_d    = DIV_LOAD;
        state_d  = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (div_q == '0) begin
          sclk_d  = 1'b1;
          div_d   = DIV_LOAD;
          state_d = S_SHIFT_HI;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_SHIFT_HI: begin
        if (div_q == '0) begin
          sclk_d   = 1'b0;
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q - BIT_W'(1);
          div_d    = DIV_LOAD;
          if (bitcnt_q == BIT_W'(1)) begin
            sdata_d = 1'b0;
            latch_d = 1'b1;
            state_d = S_LATCH;
          end else begin
            sdata_d = shreg_d[N_LEDS-1];
            state_d = S_SHIFT_LO;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (div_q == '0) begin
          latch_d = 1'b0;
          done_d  = 1'b1;
          wcnt_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0 || pending_q || refresh_now) begin
          pending_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign led_sclk   = sclk_q;
  assign led_sdata  = sdata_q;
  assign led_latch  = latch_q;
  assign frame_done = done_q;
  assign busy       = (state_q == S_SHIFT_LO) || (state_q == S_SHIFT_HI) || (state_q == S_LATCH);

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: a 4-LED instance and a minimal 1-LED instance.
module tb_led_shift_driver;

  logic       clk;
  logic       reset;
  logic [3:0] leds;
  logic       refresh_now;
  logic       sclk, sdata, latch, busy, fd;

  logic [0:0] leds1;
  logic       refresh1;
  logic       sclk1, sdata1, latch1, busy1, fd1;

  int checks = 0;
  int errors = 0;

  led_shift_driver #(.N_LEDS(4), .CLK_DIV(2), .REFRESH(8)) u_dut (
    .clk(clk), .reset(reset), .leds(leds), .refresh_now(refresh_now),
    .led_sclk(sclk), .led_sdata(sdata), .led_latch(latch), .busy(busy), .frame_done(fd)
  );

  led_shift_driver #(.N_LEDS(1), .CLK_DIV(1), .REFRESH(1)) u_dut1 (
    .clk(clk), .reset(reset), .leds(leds1), .refresh_now(refresh1),
    .led_sclk(sclk1), .led_sdata(sdata1), .led_latch(latch1), .busy(busy1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until frame_done is seen (or budget expires), optionally changing
  // leds at cycle chg_at and pulsing refresh_now at cycle ref_at.
  task automatic watch(input int budget, input int chg_at, input logic [3:0] chg_val,
                       input int ref_at, output int n, output logic done,
                       output logic [3:0] bits, output int nrise, output int lat_w,
                       output int lat_pulses, output int busy_n, output int overlap);
    logic prev_sclk, prev_lat;
    prev_sclk = sclk;
    prev_lat  = latch;
    n = 0; done = 1'b0; bits = '0; nrise = 0; lat_w = 0;
    lat_pulses = 0; busy_n = 0; overlap = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      n = i;
      if (i == chg_at) leds = chg_val;
      refresh_now = (i == ref_at);
      if (sclk && !prev_sclk) begin
        bits = {bits[2:0], sdata};
        nrise++;
      end
      if (latch) lat_w++;
      if (latch && !prev_lat) lat_pulses++;
      if (busy) busy_n++;
      if (sclk && latch) overlap++;
      prev_sclk = sclk;
      prev_lat  = latch;
      if (fd) begin
        done = 1'b1;
        break;
      end
    end
    refresh_now = 1'b0;
  endtask

  initial begin
    int n, nrise, lat_w, lat_pulses, busy_n, overlap;
    logic done;
    logic [3:0] bits;
    int hi_cnt, sd_hi, fd_idx, lat1_cnt;
    logic seen;

    reset = 1'b1; leds = '0; refresh_now = 1'b0; leds1 = 1'b1; refresh1 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_latch", latch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", fd, 0);

    // First frame shifts 1010 MSB first
    leds = 4'b1010;
    reset = 1'b0;
    watch(100, -1, 4'b0, -1, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("f1_done", done, 1);
    chk("f1_latency", n, 19);
    chk("f1_bits", bits, 4'b1010);
    chk("f1_rises", nrise, 4);
    chk("f1_latch_w", lat_w, 2);
    chk("f1_latch_pulses", lat_pulses, 1);
    chk("f1_overlap", overlap, 0);

    // Free-running period and busy duty
    watch(100, -1, 4'b0, -1, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("f2_period", n, 27);
    chk("f2_busy", busy_n, 18);
    chk("f2_bits", bits, 4'b1010);
    chk("f2_rises", nrise, 4);

    // leds change during SHIFT_HI of bit 1 does not disturb the snapshot
    watch(100, 19, 4'b0101, -1, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("f3_period", n, 27);
    chk("f3_bits", bits, 4'b1010);
    watch(100, -1, 4'b0, -1, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("f4_bits", bits, 4'b0101);

    // refresh_now during SHIFT_LO: frame unaffected, following WAIT is one cycle
    watch(100, -1, 4'b0, 9, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("f5_period", n, 27);
    chk("f5_bits", bits, 4'b0101);
    watch(100, -1, 4'b0, -1, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("f6_period", n, 20);
    chk("f6_busy", busy_n, 18);
    // refresh_now inside WAIT cuts the wait short
    watch(100, -1, 4'b0, 3, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("f7_period", n, 23);
    // Pending flag was consumed: next frame waits the full interval
    watch(100, -1, 4'b0, -1, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("f8_period", n, 27);

    // Reset in SHIFT_HI of the first bit
    leds = 4'b1101;
    for (int i = 1; i <= 11; i++) @(negedge clk);
    chk("mid_sclk_hi", sclk, 1);
    chk("mid_sdata_hi", sdata, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_sclk", sclk, 0);
    chk("mr_sdata", sdata, 0);
    chk("mr_latch", latch, 0);
    chk("mr_busy", busy, 0);
    reset = 1'b0;
    watch(100, -1, 4'b0, -1, n, done, bits, nrise, lat_w, lat_pulses, busy_n, overlap);
    chk("mr_latency", n, 19);
    chk("mr_bits", bits, 4'b1101);
    chk("mr_rises", nrise, 4);

    // Single-LED instance: 5-cycle frame
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fd1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("s_sync", seen, 1);
    hi_cnt = 0; sd_hi = 0; fd_idx = 0; lat1_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (sclk1) begin
        hi_cnt++;
        if (sdata1) sd_hi++;
      end
      if (latch1) lat1_cnt++;
      if (fd1 && fd_idx == 0) fd_idx = i;
    end
    chk("s_sclk_hi", hi_cnt, 1);
    chk("s_sdata_hi", sd_hi, 1);
    chk("s_latch", lat1_cnt, 1);
    chk("s_period", fd_idx, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
